// File: rtl/backscatter_pkg.sv
// Shared types and default timing constants for the backscatter frame scheduler.
package backscatter_pkg;

   typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

   localparam int         CLK_HZ   = 100_000_000;
   localparam int         BIT_DIV  = 100_000;
   localparam int         SUB_DIV  = 100;
   localparam logic [7:0] PREAMBLE = 8'b1010_1011;

endpackage

// File: rtl/tick_div.sv
// Free-running modulo-DIV counter; tick is high on the last count of each period.
module tick_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/backscatter_frame_sched.sv
// Host-loadable frame sequencer: preamble + payload MSB-first, optional repeats
// separated by idle gaps, serial bit gated with a free-running subcarrier.
module backscatter_frame_sched #(
   parameter int               BIT_DIV   = backscatter_pkg::BIT_DIV,
   parameter int               SUB_DIV   = backscatter_pkg::SUB_DIV,
   parameter int               PRE_W     = 8,
   parameter logic [PRE_W-1:0] PREAMBLE  = backscatter_pkg::PREAMBLE,
   parameter int               PAYLOAD_W = 20,
   parameter int               GAP_BITS  = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [PAYLOAD_W-1:0] load_data,
   input  logic [7:0]           load_repeat,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic                 sig,
   output logic                 pwm,
   output logic                 ctrl1
);

   import backscatter_pkg::*;

   localparam int LMAX_A = (PRE_W > PAYLOAD_W) ? PRE_W : PAYLOAD_W;
   localparam int LMAX   = (LMAX_A > GAP_BITS) ? ((LMAX_A > 2) ? LMAX_A : 2)
                                               : ((GAP_BITS > 2) ? GAP_BITS : 2);
   localparam int IW     = $clog2(LMAX);

   localparam logic [IW-1:0] PRE_LAST = IW'(PRE_W - 1);
   localparam logic [IW-1:0] DAT_LAST = IW'(PAYLOAD_W - 1);
   localparam logic [IW-1:0] GAP_LAST = IW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [PRE_W-1:0]       pre_q, pre_d;
   logic [PAYLOAD_W-1:0]   shift_q, shift_d;
   logic [PAYLOAD_W-1:0]   payload_q, payload_d;
   logic [7:0]             rep_q, rep_d;
   logic                   sig_q, sig_d;
   logic                   done_q, done_d;
   logic                   aborted_q, aborted_d;
   logic                   pwm_q;
   logic                   sub_tick, bit_tick, bit_clr;

   tick_div #(.DIV(SUB_DIV)) u_sub_div (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .tick(sub_tick)
   );

   // Restarting on every state change keeps each bit exactly BIT_DIV cycles long.
   assign bit_clr = (state_d != state_q);

   tick_div #(.DIV(BIT_DIV)) u_bit_div (
      .clk (clk),
      .rst (rst),
      .clr (bit_clr),
      .tick(bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pre_d     = pre_q;
      shift_d   = shift_q;
      payload_d = payload_q;
      rep_d     = rep_q;
      sig_d     = sig_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            sig_d = 1'b0;
            if (load_valid) begin
               state_d   = PRE;
               payload_d = load_data;
               shift_d   = load_data;
               rep_d     = load_repeat;
               idx_d     = PRE_LAST;
               pre_d     = PREAMBLE;
               sig_d     = PREAMBLE[PRE_W-1];
            end
         end
         PRE: if (bit_tick) begin
            if (idx_q == '0) begin
               state_d = DATA;
               idx_d   = DAT_LAST;
               sig_d   = shift_q[PAYLOAD_W-1];
            end else begin
               idx_d = idx_q - 1'b1;
               pre_d = pre_q << 1;
               sig_d = pre_d[PRE_W-1];
            end
         end
         DATA: if (bit_tick) begin
            if (idx_q != '0) begin
               idx_d   = idx_q - 1'b1;
               shift_d = shift_q << 1;
               sig_d   = shift_d[PAYLOAD_W-1];
            end else if (rep_q != '0) begin
               shift_d = payload_q;
               if (GAP_BITS == 0) begin
                  state_d = PRE;
                  rep_d   = rep_q - 1'b1;
                  idx_d   = PRE_LAST;
                  pre_d   = PREAMBLE;
                  sig_d   = PREAMBLE[PRE_W-1];
               end else begin
                  state_d = GAP;
                  idx_d   = GAP_LAST;
                  sig_d   = 1'b0;
               end
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
               sig_d   = 1'b0;
            end
         end
         GAP: begin
            sig_d = 1'b0;
            if (bit_tick) begin
               if (idx_q == '0) begin
                  state_d = PRE;
                  rep_d   = rep_q - 1'b1;
                  idx_d   = PRE_LAST;
                  pre_d   = PREAMBLE;
                  sig_d   = PREAMBLE[PRE_W-1];
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d   = IDLE;
         sig_d     = 1'b0;
         done_d    = 1'b0;
         aborted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pre_q     <= '0;
         shift_q   <= '0;
         payload_q <= '0;
         rep_q     <= '0;
         sig_q     <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         pwm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pre_q     <= pre_d;
         shift_q   <= shift_d;
         payload_q <= payload_d;
         rep_q     <= rep_d;
         sig_q     <= sig_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         pwm_q     <= pwm_q ^ sub_tick;
      end
   end

   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign sig        = sig_q;
   assign pwm        = pwm_q;
   assign ctrl1      = sig_q & pwm_q;

endmodule
